// File: rtl/vmm_fetch_pkg.sv
// rtl/vmm_fetch_pkg.sv - shared FSM encoding and default sizing for the line fetch engine
package vmm_fetch_pkg;

    localparam int VMM_AW_DEF = 14;
    localparam int VMM_FD_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FADR = 3'd1,
        ST_FDAT = 3'd2,
        ST_CADR = 3'd3,
        ST_CDAT = 3'd4
    } vmm_state_t;

    // A zero length field encodes a full 256-byte line
    function automatic logic [8:0] line_bytes(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/vmm_fifo.sv
// rtl/vmm_fifo.sv - byte FIFO holding fetched line data; head byte is combinational
module vmm_fifo
    import vmm_fetch_pkg::*;
#(
    parameter int FD = VMM_FD_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [7:0]            i_data,
    input  logic                  i_pop,
    output logic [7:0]            o_data,
    output logic [$clog2(FD):0]   o_count,
    output logic                  o_empty
);

    localparam int PW = $clog2(FD);
    localparam logic [PW:0] LV_FULL = FD[PW:0];

    logic [7:0]  r_mem [FD];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_push = i_push && !i_flush && ((r_count != LV_FULL) || w_pop);

    always_ff @(posedge clk) begin
        if (!resetn || i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

    assign o_data  = r_mem[r_rp];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/vmm_fetch.sv
// rtl/vmm_fetch.sv - video line prefetch into a byte FIFO with a shared-RAM CPU port
// Optional CPU port: VMM_FETCH_CPU_PORT_EN
module vmm_fetch
    import vmm_fetch_pkg::*;
#(
    parameter int AW = VMM_AW_DEF,
    parameter int FD = VMM_FD_DEF
) (
    input  logic          clock,
    input  logic          reset,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_di,
    input  logic [7:0]    ram_do,
    input  logic          line_start,
    input  logic [AW-1:0] line_addr,
    input  logic [7:0]    line_len,
    input  logic          pix_rd,
    output logic [7:0]    pix_do,
    output logic          pix_empty,
    output logic          line_busy,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_di,
    output logic [7:0]    cpu_do,
    output logic          cpu_ack
);

    localparam int CW = $clog2(FD) + 1;

    vmm_state_t    r_state;
    vmm_state_t    w_next;
    logic [AW-1:0] r_faddr;
    logic [8:0]    r_remain;
    logic [CW-1:0] w_count;
    logic          w_push;
    logic          w_fetch_ok;
    logic          w_cpu_req;
    logic          w_cpu_we;
    logic [AW-1:0] w_cpu_a;
    logic [7:0]    w_cpu_di;

`ifdef VMM_FETCH_CPU_PORT_EN
    logic [7:0] r_cpu_do;

    assign w_cpu_req = cpu_req;
    assign w_cpu_we  = cpu_we;
    assign w_cpu_a   = cpu_a;
    assign w_cpu_di  = cpu_di;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cpu_do <= '0;
        end else if (r_state == ST_CDAT && cpu_we) begin
            r_cpu_do <= ram_do;
        end
    end

    assign cpu_do  = r_cpu_do;
    assign cpu_ack = reset && (r_state == ST_CDAT);
`else
    logic w_unused_cpu;

    assign w_unused_cpu = ^{cpu_req, cpu_we, cpu_a, cpu_di};
    assign w_cpu_req    = 1'b0;
    assign w_cpu_we     = 1'b1;
    assign w_cpu_a      = '0;
    assign w_cpu_di     = '0;
    assign cpu_do       = '0;
    assign cpu_ack      = 1'b0;
`endif

    // Nothing is in flight while idle, so FIFO occupancy alone gates a new fetch
    assign w_fetch_ok = (r_remain != 9'd0) && (w_count < FD[CW-1:0]);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_faddr  <= '0;
            r_remain <= '0;
        end else begin
            r_state <= w_next;
            if (line_start) begin
                r_faddr  <= line_addr;
                r_remain <= line_bytes(line_len);
            end else if (r_state == ST_FADR) begin
                r_faddr  <= r_faddr + AW'(1);
                r_remain <= r_remain - 9'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        ram_ce = 1'b0;
        ram_we = 1'b1;
        ram_a  = '0;
        ram_di = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_cpu_req) begin
                    w_next = ST_CADR;
                end else if (!line_start && w_fetch_ok) begin
                    w_next = ST_FADR;
                end
            end
            ST_FADR: begin
                ram_ce = reset;
                ram_a  = reset ? r_faddr : '0;
                w_next = line_start ? ST_IDLE : ST_FDAT;
            end
            ST_FDAT: w_next = ST_IDLE;
            ST_CADR: begin
                ram_ce = reset;
                ram_we = reset ? w_cpu_we : 1'b1;
                ram_a  = reset ? w_cpu_a : '0;
                ram_di = reset ? w_cpu_di : '0;
                w_next = ST_CDAT;
            end
            ST_CDAT: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // A restart during a fetch drops the byte that is still in flight
    assign w_push    = reset && (r_state == ST_FDAT) && !line_start;
    assign line_busy = reset && ((r_remain != 9'd0) || (r_state == ST_FADR) || (r_state == ST_FDAT));

    vmm_fifo #(
        .FD (FD)
    ) u_fifo (
        .clk     (clock),
        .resetn  (reset),
        .i_flush (line_start),
        .i_push  (w_push),
        .i_data  (ram_do),
        .i_pop   (pix_rd),
        .o_data  (pix_do),
        .o_count (w_count),
        .o_empty (pix_empty)
    );

endmodule

// File: tb/tb_vmm_fetch.sv
// tb/tb_vmm_fetch.sv - self-checking bench for vmm_fetch against a RAM model and line reference
module tb_vmm_fetch;

    localparam int AW   = 14;
    localparam int FD   = 8;
    localparam int MASK = (1 << AW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_di;
    logic [7:0]    ram_do = '0;
    logic          line_start;
    logic [AW-1:0] line_addr;
    logic [7:0]    line_len;
    logic          pix_rd;
    logic [7:0]    pix_do;
    logic          pix_empty;
    logic          line_busy;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_a;
    logic [7:0]    cpu_di;
    logic [7:0]    cpu_do;
    logic          cpu_ack;

    always #5 clock = ~clock;

    vmm_fetch #(.AW(AW), .FD(FD)) dut (
        .clock(clock), .reset(reset),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
        .line_start(line_start), .line_addr(line_addr), .line_len(line_len),
        .pix_rd(pix_rd), .pix_do(pix_do), .pix_empty(pix_empty), .line_busy(line_busy),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di),
        .cpu_do(cpu_do), .cpu_ack(cpu_ack)
    );

    logic [7:0] mem [0:(1<<AW)-1];
    logic       mem_ready = 1'b0;

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'($urandom);
            mem_ready <= 1'b1;
        end else begin
            if (ram_ce && ram_we)  ram_do <= mem[ram_a];
            if (ram_ce && !ram_we) mem[ram_a] <= ram_di;
        end
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
    } acc_t;

    acc_t       acc_q[$];
    logic [7:0] popped_q[$];

    always @(negedge clock) begin
        if (ram_ce) acc_q.push_back({ram_we, ram_a});
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        int            pop_pct;
        int            exp_n;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t tbl[7];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit want_pop);
        @(negedge clock);
        #1;
        if (want_pop && !pix_empty) popped_q.push_back(pix_do);
        pix_rd = want_pop;
    endtask

    task automatic start_line(input logic [AW-1:0] a, input logic [7:0] l);
        line_addr  = a;
        line_len   = l;
        line_start = 1'b1;
        step(1'b0);
        line_start = 1'b0;
    endtask

    task automatic wait_acc(input int n, input string nm);
        int c;
        c = 0;
        while (acc_q.size() < n && c < 100) begin
            step(1'b0);
            c++;
        end
        chk(nm, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic drain(input int pct, input int bound, input string nm);
        int c;
        c = 0;
        while ((line_busy || !pix_empty) && c < bound) begin
            step($urandom_range(0, 99) < pct);
            c++;
        end
        pix_rd = 1'b0;
        chk(nm, 32'(c < bound), 32'd1);
    endtask

    // Reference: a line is the bytes at consecutive addresses modulo the RAM size, all reads
    task automatic check_line(input logic [AW-1:0] a, input int n, input string nm);
        int errs;
        int m;
        errs = 0;
        chk({nm, "_pops"}, 32'(popped_q.size()), 32'(n));
        chk({nm, "_reads"}, 32'(acc_q.size()), 32'(n));
        m = (popped_q.size() < acc_q.size()) ? popped_q.size() : acc_q.size();
        if (m > n) m = n;
        for (int i = 0; i < m; i++) begin
            if (popped_q[i] !== mem[(int'(a) + i) & MASK]) errs++;
            if (acc_q[i].a !== AW'((int'(a) + i) & MASK) || acc_q[i].we !== 1'b1) errs++;
        end
        chk({nm, "_seq"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int c;
        int occ;
        int maxocc;
        int n_ack;

        tbl[0] = '{14'h0100, 8'd4,   60, 4,   14'h0103};
        tbl[1] = '{14'h3FFE, 8'd4,   60, 4,   14'h0001};
        tbl[2] = '{14'h0000, 8'd0,   70, 256, 14'h00FF};
        tbl[3] = '{14'h1234, 8'd20,  30, 20,  14'h1247};
        tbl[4] = '{14'h3FF0, 8'd1,   50, 1,   14'h3FF0};
        tbl[5] = '{14'h2FFA, 8'd9,   90, 9,   14'h3002};
        tbl[6] = '{14'h3F80, 8'd200, 40, 200, 14'h0047};

        reset = 1'b0; line_start = 1'b1; line_addr = 14'h0123; line_len = 8'd5;
        pix_rd = 1'b1; cpu_req = 1'b0; cpu_we = 1'b1; cpu_a = '0; cpu_di = '0;
        for (int i = 0; i < 4; i++) step(1'b0);
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd1);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_ram_di", 32'(ram_di), 32'd0);
        chk("rst_cpu_do", 32'(cpu_do), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_busy", 32'(line_busy), 32'd0);
        chk("rst_empty", 32'(pix_empty), 32'd1);
        line_start = 1'b0;
        reset = 1'b1;
        acc_q.delete();
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("idle_no_access", 32'(acc_q.size()), 32'd0);

        // Basic line, no pops: busy drops right after the FDAT of the last read
        acc_q.delete(); popped_q.delete();
        start_line(14'h0100, 8'd4);
        wait_acc(4, "s1_reads");
        step(1'b0);
        chk("s1_busy_fdat", 32'(line_busy), 32'd1);
        step(1'b0);
        chk("s1_busy_fall", 32'(line_busy), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0);
        drain(100, 40, "s1_drain");
        check_line(14'h0100, 4, "s1");

        // Stall at FD bytes without pops, one extra fetch per pop
        acc_q.delete(); popped_q.delete();
        start_line(14'h0800, 8'd20);
        for (int i = 0; i < 40; i++) step(1'b0);
        chk("s3_stall_reads", 32'(acc_q.size()), 32'(FD));
        step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        chk("s3_one_more", 32'(acc_q.size()), 32'(FD + 1));
        drain(100, 400, "s3_drain");
        check_line(14'h0800, 20, "s3");

        // Restart during FDAT with three bytes queued
        acc_q.delete(); popped_q.delete();
        start_line(14'h0A00, 8'd10);
        wait_acc(4, "s4_reads");
        step(1'b0);
        acc_q.delete();
        line_addr = 14'h0B00; line_len = 8'd2; line_start = 1'b1;
        step(1'b0);
        line_start = 1'b0;
        chk("s4_flush_empty", 32'(pix_empty), 32'd1);
        popped_q.delete();
        drain(100, 100, "s4_drain");
        check_line(14'h0B00, 2, "s4");

        // Pop coinciding with a push at count five
        acc_q.delete(); popped_q.delete();
        start_line(14'h0C00, 8'd8);
        wait_acc(6, "s5_reads");
        step(1'b1);
        for (int i = 0; i < 30; i++) step(1'b0);
        chk("s5_not_empty", 32'(pix_empty), 32'd0);
        drain(100, 50, "s5_drain");
        check_line(14'h0C00, 8, "s5");

        // Reset in the middle of a fetch
        acc_q.delete(); popped_q.delete();
        start_line(14'h0D00, 8'd5);
        wait_acc(2, "s6_reads");
        reset = 1'b0;
        #1;
        chk("s6_ce_gated", 32'(ram_ce), 32'd0);
        step(1'b0);
        chk("s6_busy", 32'(line_busy), 32'd0);
        chk("s6_empty", 32'(pix_empty), 32'd1);
        chk("s6_ack", 32'(cpu_ack), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0);
        chk("s6_no_resume", 32'(acc_q.size()), 32'd2);

`ifdef VMM_FETCH_CPU_PORT_EN
        acc_q.delete(); popped_q.delete();
        start_line(14'h0E00, 8'd30);
        for (int i = 0; i < 5; i++) step($urandom_range(0, 99) < 50);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0200; cpu_di = 8'h5A;
        c = 0;
        do begin
            step($urandom_range(0, 99) < 50);
            c++;
        end while (!cpu_ack && c < 20);
        chk("cpu_wr_latency", 32'(c <= 4), 32'd1);
        cpu_req = 1'b0;
        step(1'b0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0200;
        c = 0;
        do begin
            step($urandom_range(0, 99) < 50);
            c++;
        end while (!cpu_ack && c < 20);
        chk("cpu_rd_latency", 32'(c <= 4), 32'd1);
        cpu_req = 1'b0;
        step(1'b0);
        chk("cpu_rd_data", 32'(cpu_do), 32'h5A);
        drain(100, 400, "cpu_drain");
`else
        acc_q.delete();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0200; cpu_di = 8'h5A;
        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (cpu_ack) n_ack++;
        end
        cpu_req = 1'b0;
        chk("nocpu_ram_ce", 32'(acc_q.size()), 32'd0);
        chk("nocpu_ack", 32'(n_ack), 32'd0);
        chk("nocpu_do", 32'(cpu_do), 32'd0);
`endif

        // Randomized pop pressure over a table of lines
        foreach (tbl[k]) begin
            acc_q.delete(); popped_q.delete();
            start_line(tbl[k].addr, tbl[k].len);
            maxocc = 0;
            c = 0;
            while ((line_busy || !pix_empty) && c < 5000) begin
                step($urandom_range(0, 99) < tbl[k].pop_pct);
                occ = acc_q.size() - popped_q.size();
                if (occ > maxocc) maxocc = occ;
                c++;
            end
            pix_rd = 1'b0;
            chk($sformatf("v%0d_done", k), 32'(c < 5000), 32'd1);
            check_line(tbl[k].addr, tbl[k].exp_n, $sformatf("v%0d", k));
            chk($sformatf("v%0d_last", k),
                32'((acc_q.size() > 0) ? acc_q[acc_q.size()-1].a : '0), 32'(tbl[k].exp_last));
            chk($sformatf("v%0d_occ", k), 32'(maxocc <= FD), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
